// File: rtl/cacheline_adaptor_pkg.sv
// adaptor_types: shared state encoding, default widths and data typedefs for the cache-line adaptor.
package adaptor_types;
  localparam int LINE_WIDTH = 256;
  localparam int BEAT_WIDTH = 64;
  localparam int ADDR_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  typedef logic [BEAT_WIDTH-1:0] beat_t;
  typedef logic [LINE_WIDTH-1:0] line_t;
endpackage

// File: rtl/cacheline_beat_shifter.sv
// cacheline_beat_shifter: beat counter plus fill-line assembly and writeback-line beat select.
module cacheline_beat_shifter
  import adaptor_types::*;
#(
  parameter int LINE_W = LINE_WIDTH,
  parameter int BEAT_W = BEAT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              step,
  input  logic              capture,
  input  logic [LINE_W-1:0] wdata,
  input  logic [BEAT_W-1:0] beat,
  output logic [LINE_W-1:0] fill,
  output logic [BEAT_W-1:0] wbeat,
  output logic              last
);
  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  logic [CNT_W-1:0]  k;
  logic [LINE_W-1:0] wline;
  // fill and wline are separate so a writeback never disturbs the held fill line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k     <= '0;
      fill  <= '0;
      wline <= '0;
    end else begin
      k <= clr ? '0 : step ? k + 1'b1 : k;
      if (load) wline <= wdata;
      if (step && capture) fill[BEAT_W*k +: BEAT_W] <= beat;
    end
  end
  assign wbeat = wline[BEAT_W*k +: BEAT_W];
  assign last  = k == CNT_W'(BEATS - 1);
endmodule

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns one cache-line read/write into a 4-beat 64-bit memory burst.
// Optional CACHELINE_ADAPTOR_PERF_EN adds saturating read/write/stall counters.
module cacheline_adaptor
  import adaptor_types::*;
#(
  parameter int LINE_W = LINE_WIDTH,
  parameter int BEAT_W = BEAT_WIDTH,
  parameter int ADDR_W = ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
`ifdef CACHELINE_ADAPTOR_PERF_EN
  ,
  output logic [31:0]       perf_reads,
  output logic [31:0]       perf_writes,
  output logic [31:0]       perf_stall
`endif
);
  localparam int OFF_W = $clog2(LINE_W / 8);
  state_t state, nxt;
  logic   start, load, step, last;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // writeback wins over fill when both are requested
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = write_i ? WR : read_i ? RD : IDLE;
      RD, WR:  nxt = step && last ? DONE : state;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    read_o  = state == RD;
    write_o = state == WR;
    resp_o  = state == DONE;
    start   = state == IDLE && (read_i || write_i);
    load    = state == IDLE && write_i;
    step    = resp_i && (read_o || write_o);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) address_o <= '0;
    else if (start) address_o <= {address_i[ADDR_W-1:OFF_W], OFF_W'(0)};
  end
  cacheline_beat_shifter #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) u_shift (
    .clk    (clk),
    .rst    (rst),
    .clr    (start),
    .load   (load),
    .step   (step),
    .capture(read_o),
    .wdata  (line_i),
    .beat   (burst_i),
    .fill   (line_o),
    .wbeat  (burst_o),
    .last   (last)
  );
`ifdef CACHELINE_ADAPTOR_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_reads  <= '0;
      perf_writes <= '0;
      perf_stall  <= '0;
    end else begin
      if (read_o && step && last && ~&perf_reads) perf_reads <= perf_reads + 1'b1;
      if (write_o && step && last && ~&perf_writes) perf_writes <= perf_writes + 1'b1;
      if ((read_o || write_o) && !resp_i && ~&perf_stall) perf_stall <= perf_stall + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: directed and randomized bench for cacheline_adaptor with a line/beat reference model.
module tb_cacheline_adaptor;
  logic         clk = 0, rst = 1;
  logic [255:0] line_i = '0, line_o;
  logic [31:0]  address_i = '0, address_o;
  logic         read_i = 0, write_i = 0, resp_o, read_o, write_o, resp_i = 0;
  logic [63:0]  burst_i = '0, burst_o;
`ifdef CACHELINE_ADAPTOR_PERF_EN
  logic [31:0]  perf_reads, perf_writes, perf_stall;
`endif
  int           n_assert = 0, n_fail = 0;
  logic [255:0] exp_line = '0;
  int           exp_reads = 0, exp_writes = 0, exp_stall = 0;
  logic [63:0]  beat_q[$];
  bit           pat_q[$];

  cacheline_adaptor dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o), .address_i(address_i),
    .read_i(read_i), .write_i(write_i), .resp_o(resp_o), .burst_i(burst_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
`ifdef CACHELINE_ADAPTOR_PERF_EN
    , .perf_reads(perf_reads), .perf_writes(perf_writes), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cache transaction as seen from both sides; the memory side answers with
  // pattern/queued beats when given, random ones otherwise.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] line, input int gap_pct, input bit keep_rd);
    logic [255:0] fill = '0;
    logic [31:0]  al = {addr[31:5], 5'b0};
    int           b = 0;
    bit           r;
    read_i = rd; write_i = wr; address_i = addr; line_i = line; resp_i = 0;
    @(negedge clk);
    while (b < 4) begin
      chk("busy", {read_o, write_o}, wr ? 2'b01 : 2'b10);
      chk("addr", address_o, al);
      chk("no_early_resp", resp_o, 1'b0);
      if (wr) chk("wbeat", burst_o, line[64*b +: 64]);
      r = pat_q.size() != 0 ? pat_q.pop_front() : ($urandom_range(99) >= gap_pct);
      resp_i = r;
      burst_i = (r && beat_q.size() != 0) ? beat_q.pop_front() : {$urandom, $urandom};
      if (r) begin
        fill[64*b +: 64] = burst_i;
        b++;
      end else exp_stall++;
      address_i = $urandom;
      line_i = {8{$urandom}};
      @(negedge clk);
    end
    if (wr) exp_writes++;
    else begin
      exp_reads++;
      exp_line = fill;
    end
    chk("resp", resp_o, 1'b1);
    chk("done_bus", {read_o, write_o}, 2'b00);
    chk("line", line_o, exp_line);
    resp_i = 1;
    write_i = 0;
    read_i = keep_rd & rd;
    address_i = addr;
    line_i = line;
    @(negedge clk);
    chk("resp_once", resp_o, 1'b0);
    chk("idle_bus", {read_o, write_o}, 2'b00);
    chk("line_hold", line_o, exp_line);
  endtask

  initial begin
    logic [255:0] wline;
    repeat (2) @(negedge clk);
    chk("rst_bus", {read_o, write_o, resp_o}, 3'b000);
    chk("rst_line", line_o, '0);
    chk("rst_burst", burst_o, '0);
    chk("rst_addr", address_o, '0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_idle", {read_o, write_o, resp_o}, 3'b000);

    // read without gaps: resp_o lands on cycle 5
    beat_q = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    run_txn(1, 0, 32'h0000_1234, '0, 0, 0);
    chk("read_line", line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

    // write with gaps
    wline = {64'hAAAA_AAAA_0003_0003, 64'hAAAA_AAAA_0002_0002,
             64'hAAAA_AAAA_0001_0001, 64'hAAAA_AAAA_0000_0000};
    pat_q = '{1, 0, 0, 1, 1, 0, 1};
    run_txn(0, 1, 32'h0000_8040, wline, 0, 0);
`ifdef CACHELINE_ADAPTOR_PERF_EN
    chk("perf_stall3", perf_stall, 32'd3);
`endif

    // simultaneous request: writeback, then the fill with the same address
    run_txn(1, 1, 32'hDEAD_BEEF, {8{32'h5A5A_0F0F}}, 30, 1);
    run_txn(1, 0, 32'hDEAD_BEEF, '0, 30, 0);

    // stray resp_i while idle
    repeat (4) begin
      resp_i = 1;
      @(negedge clk);
      chk("stray_idle", {read_o, write_o, resp_o}, 3'b000);
      chk("stray_line", line_o, exp_line);
    end
    run_txn(1, 0, 32'h0000_0100, '0, 0, 0);

    // async reset in the middle of a read
    read_i = 1; address_i = 32'h0000_2000; resp_i = 0;
    @(negedge clk);
    repeat (2) begin
      resp_i = 1; burst_i = {$urandom, $urandom};
      @(negedge clk);
    end
    #2 rst = 1;
    #1;
    chk("abort_bus", {read_o, write_o, resp_o}, 3'b000);
    chk("abort_line", line_o, '0);
    chk("abort_addr", address_o, '0);
    @(negedge clk);
    read_i = 0; resp_i = 0; rst = 0;
    exp_line = '0; exp_reads = 0; exp_writes = 0; exp_stall = 0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_resp", {read_o, resp_o}, 2'b00);
    end
    run_txn(1, 0, 32'h0000_2000, '0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      bit w = $urandom_range(1);
      run_txn(!w, w, $urandom, {8{$urandom}}, $urandom_range(60), 0);
    end
`ifdef CACHELINE_ADAPTOR_PERF_EN
    chk("perf_reads", perf_reads, 32'(exp_reads));
    chk("perf_writes", perf_writes, 32'(exp_writes));
    chk("perf_stall", perf_stall, 32'(exp_stall));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
